// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the 5-stage rv32i pipeline: per-cycle buffer load
// enables, flush strobes, PC redirect, and saturating performance counters.
module pipeline_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_resp,
    input  logic             dmem_access,
    input  logic             dmem_resp,
    input  logic [4:0]       de_rs1,
    input  logic [4:0]       de_rs2,
    input  logic             de_use_rs1,
    input  logic             de_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             br_mispredict,
    output logic             load_pc,
    output logic             load_if_de,
    output logic             load_de_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_de,
    output logic             flush_de_ex,
    output logic             pc_redirect,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IWAIT = 2'd1,
        DWAIT = 2'd2,
        REDIR = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   dstall;
    logic   mp;
    logic   lu;
    logic   inc_stall;
    logic   inc_flush;
    logic   inc_bubble;

    assign state = state_q;

    // Hazard detection; a mispredict right after a redirect belongs to the squashed path
    always_comb begin
        dstall = dmem_access & ~dmem_resp;
        mp     = br_mispredict & (state_q != REDIR);
        lu     = ex_mem_read & (ex_rd != 5'd0) &
                 ((de_use_rs1 & (de_rs1 == ex_rd)) | (de_use_rs2 & (de_rs2 == ex_rd)));
    end

    // Prioritised enable/flush generation and next-state selection
    always_comb begin
        load_pc     = 1'b0;
        load_if_de  = 1'b0;
        load_de_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_de = 1'b0;
        flush_de_ex = 1'b0;
        pc_redirect = 1'b0;
        inc_stall   = 1'b0;
        inc_flush   = 1'b0;
        inc_bubble  = 1'b0;
        state_d     = RUN;

        if (dstall) begin
            inc_stall = 1'b1;
            state_d   = DWAIT;
        end else if (mp && !imem_resp) begin
            // PC must hold until the in-flight fetch retires
            inc_stall = 1'b1;
            state_d   = IWAIT;
        end else if (mp) begin
            load_pc     = 1'b1;
            pc_redirect = 1'b1;
            load_if_de  = 1'b1;
            flush_if_de = 1'b1;
            load_de_ex  = 1'b1;
            flush_de_ex = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            inc_flush   = 1'b1;
            state_d     = REDIR;
        end else if (lu) begin
            load_de_ex  = 1'b1;
            flush_de_ex = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            inc_stall   = 1'b1;
            inc_bubble  = 1'b1;
            state_d     = RUN;
        end else if (!imem_resp) begin
            load_if_de  = 1'b1;
            flush_if_de = 1'b1;
            load_de_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            inc_stall   = 1'b1;
            state_d     = IWAIT;
        end else begin
            load_pc     = 1'b1;
            load_if_de  = 1'b1;
            load_de_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            state_d     = RUN;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            state_q    <= state_d;
            stall_cnt  <= sat_inc(stall_cnt, inc_stall);
            flush_cnt  <= sat_inc(flush_cnt, inc_flush);
            bubble_cnt <= sat_inc(bubble_cnt, inc_bubble);
        end
    end

endmodule
